// File: rtl/secded_stream_encoder.sv
// Pipelined SECDED (extended Hamming) encoder with a valid/ready stream interface.
// Define SECDED_STREAM_ENCODER_ERR_INJ_EN to build in single-word error injection.
module secded_stream_encoder #(
  parameter int DATA_W = 32,
  parameter int PIPE   = 2,
  parameter int CNT_W  = 16,
  localparam int P      = (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 :
                          (DATA_W <= 57) ? 6 : 7,
  localparam int CODE_W = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CODE_W-1:0] m_data,
  output logic [CNT_W-1:0]  word_cnt,
  input  logic              inj_arm,
  input  logic [CODE_W-1:0] inj_mask,
  output logic              inj_pending
);

  // Handshake: a word moves across an interface on a rising edge where valid
  // and ready are both high; a stage advances when it is empty or its
  // successor advances, and a held output keeps valid and data stable.
  logic              started;
  logic              s_fire;
  logic              out_adv;
  logic              first_adv;
  logic              fin_valid;
  logic [DATA_W-1:0] fin_data;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] inj_xor;

  assign out_adv = !m_valid || m_ready;
  assign s_ready = started && enable && first_adv;
  assign s_fire  = s_valid && s_ready;

  // Holds intake closed until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) started <= 1'b0;
    else        started <= 1'b1;
  end

  generate
    if (PIPE >= 2) begin : g_in_reg
      logic              s0_valid;
      logic [DATA_W-1:0] s0_data;

      assign first_adv = !s0_valid || out_adv;
      assign fin_valid = s0_valid;
      assign fin_data  = s0_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s0_valid <= 1'b0;
          s0_data  <= '0;
        end else if (first_adv) begin
          s0_valid <= s_fire;
          if (s_fire) s0_data <= s_data;
        end
      end
    end else begin : g_direct
      assign first_adv = out_adv;
      assign fin_valid = s_fire;
      assign fin_data  = s_data;
    end
  endgenerate

  // Data fills non-power-of-two positions from 3 upward; each parity bit then
  // covers the positions carrying its index bit, and bit 0 covers the rest.
  always_comb begin
    int j;
    logic par;
    code = '0;
    j    = 0;
    par  = 1'b0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        code[i] = fin_data[j];
        j = j + 1;
      end
    end
    for (int k = 0; k < P; k++) begin
      par = 1'b0;
      for (int i = 1; i < CODE_W; i++) begin
        if (i[k]) par = par ^ code[i];
      end
      code[1 << k] = par;
    end
    code[0] = ^code[CODE_W-1:1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (out_adv) begin
      m_valid <= fin_valid;
      if (fin_valid) m_data <= code ^ inj_xor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  word_cnt <= '0;
    else if (m_valid && m_ready) word_cnt <= word_cnt + 1'b1;
  end

`ifdef SECDED_STREAM_ENCODER_ERR_INJ_EN
  logic              pend_q;
  logic [CODE_W-1:0] mask_q;

  assign inj_pending = pend_q;
  assign inj_xor     = pend_q ? mask_q : '0;

  // A re-arm in the same cycle as a load keeps the injection pending with the new mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      mask_q <= '0;
    end else if (inj_arm) begin
      pend_q <= 1'b1;
      mask_q <= inj_mask;
    end else if (pend_q && out_adv && fin_valid) begin
      pend_q <= 1'b0;
    end
  end
`else
  logic unused_inj;
  assign unused_inj  = ^{inj_arm, inj_mask};
  assign inj_pending = 1'b0;
  assign inj_xor     = '0;
`endif

endmodule

// File: tb/tb_secded_stream_encoder.sv
// Directed scoreboard bench for secded_stream_encoder at DATA_W=32, PIPE=2.
module tb_secded_stream_encoder;
  localparam int DW = 32;
  localparam int CW = 39;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] m_data;
  logic [15:0]   word_cnt;
  logic          inj_arm = 1'b0;
  logic [CW-1:0] inj_mask = '0;
  logic          inj_pending;

  logic mr_fixed = 1'b1;
  logic mr_rand  = 1'b1;
  logic rand_mr  = 1'b0;
  assign m_ready = rand_mr ? mr_rand : mr_fixed;

  int passed = 0;
  int total  = 0;
  logic [CW-1:0] exp_q[$];
  bit            dec_q[$];

  secded_stream_encoder #(.DATA_W(DW), .PIPE(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .word_cnt(word_cnt), .inj_arm(inj_arm), .inj_mask(inj_mask),
    .inj_pending(inj_pending)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    #1;
    mr_rand = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference encoder: XOR of the positions of set data bits gives the parity bits.
  function automatic logic [CW-1:0] ref_enc(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    logic [5:0]    syn;
    int            j;
    c = '0; syn = '0; j = 0;
    for (int pos = 1; pos < CW; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[j];
        if (d[j]) syn = syn ^ 6'(pos);
        j++;
      end
    end
    for (int k = 0; k < 6; k++) c[1 << k] = syn[k];
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  // Scoreboard monitor
  logic          hold = 1'b0;
  logic [CW-1:0] hold_data = '0;
  always @(negedge clk) begin
    logic [CW-1:0] e;
    logic [5:0]    syn;
    bit            d;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data", 64'(m_data), 64'(hold_data));
      end
      hold      = m_valid && !m_ready;
      hold_data = m_data;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_word: got 0x%0h with no word expected", m_data);
        end else begin
          e = exp_q.pop_front();
          d = dec_q.pop_front();
          chk("codeword", 64'(m_data), 64'(e));
          if (d) begin
            syn = '0;
            for (int i = 1; i < CW; i++) if (m_data[i]) syn = syn ^ 6'(i);
            chk("decode_syndrome", 64'(syn), 64'd0);
            chk("decode_parity", 64'(^m_data), 64'd0);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] e, input bit dec);
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (s_ready) begin
        exp_q.push_back(e);
        dec_q.push_back(dec);
        done = 1'b1;
      end
      step();
    end
    s_valid = 1'b0;
    if (!done) begin
      total++;
      $display("FAIL send_timeout: word 0x%0h never accepted", d);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) step();
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
      exp_q.delete();
      dec_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  logic [DW-1:0] bp_w[4] = '{32'h1, 32'h2, 32'h4, 32'h8};
  logic [CW-1:0] bp_e[4] = '{39'hF, 39'h33, 39'h55, 39'h96};

  initial begin
    int  idx;
    bit  r;
    logic [DW-1:0] d;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    chk("rst_inj_pending", 64'(inj_pending), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    chk("first_edge_s_ready", 64'(s_ready), 64'd1);
    step();

    // Basic vectors and two-cycle latency
    send(32'h0, 39'h0, 1'b1);
    @(negedge clk);
    chk("latency_cycle1", 64'(m_valid), 64'd0);
    @(negedge clk);
    chk("latency_cycle2", 64'(m_valid), 64'd1);
    step();
    send(32'h1, 39'hF, 1'b1);
    send(32'h2, 39'h33, 1'b1);
    drain();
    chk("cnt_basic", 64'(word_cnt), 64'd3);

    // Back-pressure: only two words fit, then release with no gap
    mr_fixed = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      s_valid = 1'b1;
      s_data  = bp_w[idx];
      @(negedge clk);
      r = s_ready;
      if (r) begin exp_q.push_back(bp_e[idx]); dec_q.push_back(1'b1); end
      step();
      if (r) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    @(negedge clk);
    chk("bp_s_ready", 64'(s_ready), 64'd0);
    step();
    mr_fixed = 1'b1;
    for (int c = 0; c < 4; c++) begin
      s_valid = (idx < 4);
      s_data  = (idx < 4) ? bp_w[idx] : '0;
      @(negedge clk);
      chk("bp_no_gap", 64'(m_valid), 64'd1);
      r = s_valid && s_ready;
      if (r) begin exp_q.push_back(bp_e[idx]); dec_q.push_back(1'b1); end
      step();
      if (r) idx++;
    end
    s_valid = 1'b0;
    chk("bp_all_accepted", 64'(idx), 64'd4);
    drain();
    chk("cnt_bp", 64'(word_cnt), 64'd7);

    // Intake disabled with two words in flight
    send(32'h3, 39'h3C, 1'b1);
    send(32'h4, 39'h55, 1'b1);
    enable  = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h8;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("en_blocked", 64'(s_ready), 64'd0);
      step();
    end
    chk("en_drained", 64'(exp_q.size()), 64'd0);
    enable = 1'b1;
    send(32'h8, 39'h96, 1'b1);
    drain();
    chk("cnt_enable", 64'(word_cnt), 64'd10);

    // Error injection
    inj_arm  = 1'b1;
    inj_mask = 39'h4;
    step();
    inj_arm  = 1'b0;
    inj_mask = '0;
`ifdef SECDED_STREAM_ENCODER_ERR_INJ_EN
    chk("inj_armed", 64'(inj_pending), 64'd1);
    send(32'h1, 39'hB, 1'b0);
    drain();
    chk("inj_cleared", 64'(inj_pending), 64'd0);
    send(32'h1, 39'hF, 1'b1);
    drain();
`else
    chk("inj_never_pending", 64'(inj_pending), 64'd0);
    send(32'h1, 39'hF, 1'b1);
    send(32'h1, 39'hF, 1'b1);
    drain();
`endif
    chk("cnt_inj", 64'(word_cnt), 64'd12);

    // Random stream with random m_ready
    do_reset();
    rand_mr = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) step();
      d = $urandom;
      send(d, ref_enc(d), 1'b1);
    end
    drain();
    rand_mr  = 1'b0;
    mr_fixed = 1'b1;
    step();
    chk("cnt_random", 64'(word_cnt), 64'd1000);

    // Reset mid-stream with two words in flight and an armed injection
    mr_fixed = 1'b0;
    inj_arm  = 1'b1;
    inj_mask = 39'h1;
    step();
    inj_arm  = 1'b0;
    send(32'h5, ref_enc(32'h5), 1'b0);
    send(32'h6, ref_enc(32'h6), 1'b0);
    chk("mid_full_valid", 64'(m_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_word_cnt", 64'(word_cnt), 64'd0);
    chk("mid_rst_inj_pending", 64'(inj_pending), 64'd0);
    exp_q.delete();
    dec_q.delete();
    step();
    rst_n    = 1'b1;
    mr_fixed = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("no_stale_word", 64'(m_valid), 64'd0);
    end
    chk("cnt_after_mid_rst", 64'(word_cnt), 64'd0);

    // Final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
